// File: rtl/joy_pkg.sv
// Shared constants and the joystick-to-keyboard mapping used by the joystick mapper.
// Raw joystick words are MXYZ SACB RLDU, negative logic; Kempston words are positive logic.
package joy_pkg;

    localparam int BIT_U = 0;
    localparam int BIT_D = 1;
    localparam int BIT_L = 2;
    localparam int BIT_R = 3;
    localparam int BIT_B = 4;
    localparam int BIT_C = 5;
    localparam int BIT_A = 6;
    localparam int BIT_S = 7;
    localparam int BIT_Z = 8;
    localparam int BIT_Y = 9;
    localparam int BIT_X = 10;
    localparam int BIT_M = 11;

    typedef enum logic [1:0] {
        MODE_KEMPSTON  = 2'b00,
        MODE_SINCLAIR1 = 2'b01,
        MODE_SINCLAIR2 = 2'b10,
        MODE_CURSOR    = 2'b11
    } joy_mode_t;

    localparam int KEMP_R = 0;
    localparam int KEMP_L = 1;
    localparam int KEMP_D = 2;
    localparam int KEMP_U = 3;
    localparam int KEMP_B = 4;
    localparam int KEMP_C = 5;
    localparam int KEMP_A = 6;
    localparam int KEMP_S = 7;

    localparam int ROW_A11 = 3;
    localparam int ROW_A12 = 4;

    // One 5-bit positive-logic key column group per address line A8..A15.
    typedef logic [7:0][4:0] key_matrix_t;

    function automatic key_matrix_t map_keys(joy_mode_t mode, logic [7:0] kw);
        key_matrix_t m;
        logic fire;
        fire = kw[KEMP_B] | kw[KEMP_C] | kw[KEMP_A];
        m = '0;
        case (mode)
            MODE_SINCLAIR1: m[ROW_A12] = {kw[KEMP_L], kw[KEMP_R], kw[KEMP_D], kw[KEMP_U], fire};
            MODE_SINCLAIR2: m[ROW_A11] = {fire, kw[KEMP_U], kw[KEMP_D], kw[KEMP_R], kw[KEMP_L]};
            MODE_CURSOR: begin
                m[ROW_A12]    = {kw[KEMP_D], kw[KEMP_U], kw[KEMP_R], 1'b0, fire};
                m[ROW_A11][4] = kw[KEMP_L];
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/joy_channel.sv
// One joystick: per-bit debounce on sample ticks, fire-B autofire and SOCD cleaning,
// producing a positive-logic Kempston-format word and a registered change flag.
module joy_channel
    import joy_pkg::*;
#(
    parameter int DEB_COUNT = 4,
    parameter int AF_HALF   = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [11:0] raw,
    input  logic        autofire,
    output logic [7:0]  kword,
    output logic        changed
);

    logic [11:0]      deb;
    logic [11:0][3:0] deb_cnt;
    logic             b_pressed;
    logic             phase;
    logic [7:0]       af_cnt;

    assign b_pressed = ~deb[BIT_B];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb     <= '1;
            deb_cnt <= '0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (tick) begin
                for (int i = 0; i < 12; i++) begin
                    if (raw[i] == deb[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] == 4'(DEB_COUNT - 1)) begin
                        deb[i]     <= raw[i];
                        deb_cnt[i] <= '0;
                        changed    <= 1'b1;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Phase is held at "pressed" whenever autofire is idle, so every press starts high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase  <= 1'b1;
            af_cnt <= '0;
        end else if (!(autofire && b_pressed)) begin
            phase  <= 1'b1;
            af_cnt <= '0;
        end else if (tick) begin
            if (af_cnt == 8'(AF_HALF - 1)) begin
                phase  <= ~phase;
                af_cnt <= '0;
            end else begin
                af_cnt <= af_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        kword         = '0;
        kword[KEMP_R] = ~deb[BIT_R] & deb[BIT_L];
        kword[KEMP_L] = ~deb[BIT_L] & deb[BIT_R];
        kword[KEMP_D] = ~deb[BIT_D] & deb[BIT_U];
        kword[KEMP_U] = ~deb[BIT_U] & deb[BIT_D];
        kword[KEMP_B] = b_pressed & (phase | ~autofire);
        kword[KEMP_C] = ~deb[BIT_C];
        kword[KEMP_A] = ~deb[BIT_A];
        kword[KEMP_S] = ~deb[BIT_S];
    end

endmodule

// File: rtl/joystick_mapper.sv
// Joystick mapper top: sample-tick prescaler, input synchronisers, two joystick channels,
// and the registered Kempston port byte / keyboard column contribution.
module joystick_mapper
    import joy_pkg::*;
#(
    parameter int TICK_DIV  = 28000,
    parameter int DEB_COUNT = 4,
    parameter int AF_HALF   = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] joy1_i,
    input  logic [11:0] joy2_i,
    input  logic [1:0]  mode1,
    input  logic [1:0]  mode2,
    input  logic        autofire1,
    input  logic        autofire2,
    input  logic [7:0]  addr_hi_n,
    output logic [7:0]  kempston_o,
    output logic [4:0]  key_col_n,
    output logic        joy_event
);

    localparam int PW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tick;
    logic [11:0]   joy1_s1, joy1_s2, joy2_s1, joy2_s2;
    logic [7:0]    kw1, kw2;
    logic          ch1, ch2;
    key_matrix_t   keys;
    logic [7:0]    kemp_next;
    logic [4:0]    col_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            tick    <= 1'b0;
            joy1_s1 <= '1;
            joy1_s2 <= '1;
            joy2_s1 <= '1;
            joy2_s2 <= '1;
        end else begin
            tick    <= (presc == PW'(TICK_DIV - 1));
            presc   <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
            joy1_s1 <= joy1_i;
            joy1_s2 <= joy1_s1;
            joy2_s1 <= joy2_i;
            joy2_s2 <= joy2_s1;
        end
    end

    joy_channel #(.DEB_COUNT(DEB_COUNT), .AF_HALF(AF_HALF)) u_joy1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .raw      (joy1_s2),
        .autofire (autofire1),
        .kword    (kw1),
        .changed  (ch1)
    );

    joy_channel #(.DEB_COUNT(DEB_COUNT), .AF_HALF(AF_HALF)) u_joy2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .raw      (joy2_s2),
        .autofire (autofire2),
        .kword    (kw2),
        .changed  (ch2)
    );

    // Selected rows are ANDed exactly like the ULA does for multiple low address lines.
    always_comb begin
        keys      = map_keys(joy_mode_t'(mode1), kw1) | map_keys(joy_mode_t'(mode2), kw2);
        kemp_next = '0;
        if (joy_mode_t'(mode1) == MODE_KEMPSTON) kemp_next = kemp_next | kw1;
        if (joy_mode_t'(mode2) == MODE_KEMPSTON) kemp_next = kemp_next | kw2;
        col_next = '1;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi_n[r]) col_next = col_next & ~keys[r];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kempston_o <= '0;
            key_col_n  <= '1;
            joy_event  <= 1'b0;
        end else begin
            kempston_o <= kemp_next;
            key_col_n  <= col_next;
            joy_event  <= ch1 | ch2;
        end
    end

endmodule

// File: tb/tb_joystick_mapper.sv
// Self-checking bench for joystick_mapper: directed scenarios plus randomized stimulus,
// checked once per sample tick against a tick-level behavioural model.
module tb_joystick_mapper;

    localparam int TD  = 8;
    localparam int DEB = 4;
    localparam int AFH = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] joy1, joy2;
    logic [1:0]  mode1, mode2;
    logic        af1_en, af2_en;
    logic [7:0]  addr;
    logic [7:0]  kempston;
    logic [4:0]  key_col_n;
    logic        joy_event;

    joystick_mapper #(.TICK_DIV(TD), .DEB_COUNT(DEB), .AF_HALF(AFH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy1_i     (joy1),
        .joy2_i     (joy2),
        .mode1      (mode1),
        .mode2      (mode2),
        .autofire1  (af1_en),
        .autofire2  (af2_en),
        .addr_hi_n  (addr),
        .kempston_o (kempston),
        .key_col_n  (key_col_n),
        .joy_event  (joy_event)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int          n_cmp, n_fail;
    int          k;
    logic [11:0] m_deb  [2];
    logic [11:0] m_hist [2][DEB];
    int          m_af   [2];

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_deb[j] = '1;
            m_af[j]  = 0;
            for (int w = 0; w < DEB; w++) m_hist[j][w] = '1;
        end
    endtask

    function automatic logic [7:0] kword(logic [11:0] d, int af, logic en);
        logic u, dn, l, r, b;
        u = !d[0]; dn = !d[1]; l = !d[2]; r = !d[3];
        if (u && dn) begin u = 1'b0; dn = 1'b0; end
        if (l && r)  begin l = 1'b0; r = 1'b0;  end
        b = !d[4] && (!en || ((af / AFH) % 2 == 0));
        return {!d[7], !d[6], !d[5], b, u, dn, l, r};
    endfunction

    // Flattened key matrix: address line index * 5 + column.
    function automatic logic [39:0] keymap(logic [1:0] mode, logic [7:0] kw);
        logic [39:0] m;
        logic fire;
        m = '0;
        fire = kw[4] | kw[5] | kw[6];
        case (mode)
            2'b01: begin m[20] = fire; m[21] = kw[3]; m[22] = kw[2]; m[23] = kw[0]; m[24] = kw[1]; end
            2'b10: begin m[15] = kw[1]; m[16] = kw[0]; m[17] = kw[2]; m[18] = kw[3]; m[19] = fire; end
            2'b11: begin m[19] = kw[1]; m[24] = kw[2]; m[23] = kw[3]; m[22] = kw[0]; m[20] = fire; end
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] exp_kemp();
        logic [7:0] e;
        e = '0;
        if (mode1 == 2'b00) e = e | kword(m_deb[0], m_af[0], af1_en);
        if (mode2 == 2'b00) e = e | kword(m_deb[1], m_af[1], af2_en);
        return e;
    endfunction

    function automatic logic [4:0] exp_col();
        logic [39:0] m;
        logic [4:0]  c;
        m = keymap(mode1, kword(m_deb[0], m_af[0], af1_en)) |
            keymap(mode2, kword(m_deb[1], m_af[1], af2_en));
        c = '1;
        for (int r = 0; r < 8; r++) if (!addr[r]) c = c & ~m[r*5 +: 5];
        return c;
    endfunction

    // A bit flips once the last DEB samples all disagree with its debounced value.
    task automatic model_tick(output logic ev);
        logic [11:0] s [2];
        logic        en, all_diff;
        ev = 1'b0;
        s[0] = joy1;
        s[1] = joy2;
        for (int j = 0; j < 2; j++) begin
            en = (j == 0) ? af1_en : af2_en;
            if (en && !m_deb[j][4]) m_af[j]++;
            for (int w = DEB - 1; w > 0; w--) m_hist[j][w] = m_hist[j][w-1];
            m_hist[j][0] = s[j];
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                for (int w = 0; w < DEB; w++) if (m_hist[j][w][b] == m_deb[j][b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[j][b] = ~m_deb[j][b];
                    ev = 1'b1;
                end
            end
            if (!(en && !m_deb[j][4])) m_af[j] = 0;
        end
    endtask

    task automatic wait_cyc(int target);
        int guard;
        guard = 0;
        while (cyc != target) begin
            @(negedge clk);
            guard++;
            if (guard > 4 * TD) begin
                $display("FAIL wait_cyc: cycle %0d never reached %0d", cyc, target);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Tick k acts on clock edge k*TD+1 after reset release; outputs follow one clock later.
    task automatic do_tick();
        int   t;
        logic ev;
        t = k * TD + 1;
        wait_cyc(t);
        check("kemp_pre", 12'(kempston), 12'(exp_kemp()));
        check("col_pre", 12'(key_col_n), 12'(exp_col()));
        check("event_idle", 12'(joy_event), 12'd0);
        model_tick(ev);
        wait_cyc(t + 1);
        check("kemp", 12'(kempston), 12'(exp_kemp()));
        check("col", 12'(key_col_n), 12'(exp_col()));
        check("event", 12'(joy_event), 12'(ev));
        k++;
    endtask

    initial begin
        int         toggles;
        logic       prev_b;
        logic [7:0] addr_tab [4];
        addr_tab[0] = 8'hF7; addr_tab[1] = 8'hEF; addr_tab[2] = 8'hE7; addr_tab[3] = 8'hFF;
        n_cmp = 0;
        n_fail = 0;
        joy1 = '1; joy2 = '1; mode1 = 2'b00; mode2 = 2'b00;
        af1_en = 1'b0; af2_en = 1'b0; addr = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        k = 1;

        // Idle after reset
        repeat (3) do_tick();
        check("rst_kemp", 12'(kempston), 12'h000);
        check("rst_col", 12'(key_col_n), 12'h01F);

        // Kempston up, held long enough
        joy1 = 12'hFFE;
        repeat (4) do_tick();
        check("up_kemp", 12'(kempston), 12'h008);
        joy1 = '1;
        repeat (4) do_tick();

        // Glitch of DEB-1 ticks is rejected
        joy1 = 12'hFFE;
        repeat (3) do_tick();
        joy1 = '1;
        repeat (4) do_tick();
        check("glitch_kemp", 12'(kempston), 12'h000);

        // Sinclair1 fire + right
        mode1 = 2'b01;
        addr = 8'hEF;
        joy1 = 12'hFE7;
        repeat (5) do_tick();
        check("s1_col", 12'(key_col_n), 12'h016);
        addr = 8'hF7;
        @(negedge clk);
        check("s1_row_off", 12'(key_col_n), 12'h01F);
        joy1 = '1;
        repeat (4) do_tick();

        // Autofire on fire B, Kempston
        mode1 = 2'b00;
        af1_en = 1'b1;
        joy1 = 12'hFEF;
        toggles = 0;
        prev_b = 1'b0;
        repeat (DEB + 10 * AFH) begin
            do_tick();
            if (kempston[4] != prev_b) toggles++;
            prev_b = kempston[4];
        end
        check("af_toggles", 12'(toggles), 12'd11);
        joy1 = '1;
        repeat (4) do_tick();
        check("af_release", 12'(kempston[4]), 12'd0);
        af1_en = 1'b0;
        m_af[0] = 0;

        // SOCD on joystick 1, Cursor left on joystick 2, then asynchronous reset
        mode2 = 2'b11;
        addr = 8'hF7;
        joy1 = 12'hFEC;
        joy2 = 12'hFFB;
        repeat (5) do_tick();
        check("socd_ud", 12'(kempston[3:2]), 12'd0);
        check("socd_kemp", 12'(kempston), 12'h010);
        check("cursor_col", 12'(key_col_n), 12'h00F);
        #2 reset_n = 1'b0;
        #1;
        check("arst_kemp", 12'(kempston), 12'h000);
        check("arst_col", 12'(key_col_n), 12'h01F);
        check("arst_event", 12'(joy_event), 12'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        k = 1;
        repeat (5) do_tick();

        // Randomized operation
        repeat (300) begin
            if ($urandom_range(0, 4) == 0) joy1 = ~12'($urandom & $urandom);
            if ($urandom_range(0, 4) == 0) joy2 = ~12'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) mode1 = 2'($urandom);
            if ($urandom_range(0, 9) == 0) mode2 = 2'($urandom);
            if ($urandom_range(0, 3) == 0) addr = addr_tab[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0) addr = 8'($urandom);
            if ($urandom_range(0, 19) == 0) af1_en = 1'($urandom);
            if ($urandom_range(0, 19) == 0) af2_en = 1'($urandom);
            if (!af1_en) m_af[0] = 0;
            if (!af2_en) m_af[1] = 0;
            do_tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
